counter_updown_mod: RTL and testbench
=====================================

# counter_updown_mod

- Parametrised up/down modulo counter; successor to the fixed 4-bit load counter.
- Adds runtime direction, a programmable terminal value, and three end-of-range modes: wrap, saturate and one-shot.
- Provides terminal-count, wrap-pulse and done status.
- Used as a general timer/sequencer primitive by control blocks that need bounded counting without external compare logic.

## Interface
Parameters:
- WIDTH, 8, counter width in bits (≥2).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- en_i  in  1  count enable; one step per cycle while high.
- load_i  in  1  load count from load_val_i.
- load_val_i  in  WIDTH  load value.
- up_i  in  1  direction: 1 = up, 0 = down.
- limit_i  in  WIDTH  upper bound; counting range is 0..limit_i.
- mode_i  in  2  end-of-range mode: 00 WRAP, 01 SAT, 10 ONESHOT, 11 reserved (behaves as WRAP).
- count_o  out  WIDTH  current count (registered).
- tc_o  out  1  count is at terminal for current direction.
- wrap_o  out  1  registered one-cycle pulse, high the cycle after a wrap.
- done_o  out  1  ONESHOT finished; sticky until load or reset.

## Operation
- Priority per cycle: reset > load_i > en_i > hold.
- Load:
  - count <= min(load_val_i, limit_i); values above the limit are clamped.
  - Clears done_o; FSM returns to RUN.
  - No wrap_o pulse.
- Terminal:
  - Up: count ≥ limit_i. Using ≥ covers limit_i being lowered below the current count.
  - Down: count == 0.
- tc_o = terminal condition on count_ff with current up_i/limit_i. It is combinational from the register and inputs, with no added latency.
- Step with en_i=1, not at terminal: count ± 1.
- Step with en_i=1, at terminal:
  - WRAP/reserved, up: count <= 0; wrap_o pulses next cycle.
  - WRAP/reserved, down: count <= limit_i; wrap_o pulses next cycle.
  - SAT: count holds at its value; no wrap_o.
  - ONESHOT: count holds; FSM RUN→DONE; done_o high from next cycle.
- FSM states:
  - RUN (reset state): normal counting.
  - DONE: en_i ignored, count frozen, done_o=1.
  - Exits: DONE→RUN only on load_i. reset forces RUN from any state.
- Changing mode_i while in DONE does not leave DONE.
- Changing up_i or limit_i takes effect on the same cycle's next-value computation.
- Down-counting with count > limit_i (limit lowered) decrements normally until 0.
- limit_i = 0: count pinned to 0. In WRAP each enabled cycle is a wrap, so wrap_o stays high continuously.
- All arithmetic is WIDTH-bit unsigned. Up-wrap never relies on natural overflow; it uses the explicit compare.

## Timing
- Reset values: count_o=0, wrap_o=0, done_o=0, FSM=RUN.
- tc_o after reset is 1 if up_i=0 or limit_i=0, else 0.
- Latency: count_o reflects load/step one cycle after the sampling edge.
- wrap_o is aligned with the cycle in which the wrapped value (0 or limit) first appears on count_o.
- done_o is aligned with the first cycle of DONE.
- Reset mid-operation (any state, with load_i/en_i active): the next cycle shows all reset values; load and en are ignored.
- load_i and en_i in the same cycle: load wins, no step.

## Structure
- Package counter_pkg holds:
  - typedef enum logic [1:0] cnt_mode_t {CNT_WRAP, CNT_SAT, CNT_ONESHOT, CNT_RSVD}.
  - typedef enum logic cnt_state_t {ST_RUN, ST_DONE}.
- Single module with:
  - one always_ff for count_ff, state_ff and wrap_ff;
  - one always_comb for next-value, terminal detect and next state.
- No sub-module needed.

## Test plan
Tests use WIDTH=4.
- WRAP, up, limit 9, en for 12 cycles from reset:
  - count 1..9,0,1,2;
  - tc_o high while count=9;
  - wrap_o high exactly in the cycle count shows 0.
- SAT, down, load 3 then en for 6 cycles:
  - count 2,1,0,0,0,0;
  - tc_o high from count=0;
  - wrap_o never asserted.
- ONESHOT, up, limit 5 from 0, en held:
  - count reaches 5; next enabled cycle done_o=1, count stays 5 for 4 more enabled cycles;
  - load_i with value 2 → count 2, done_o=0, counting resumes 3,4.
- Load clamp and priority:
  - load_val 12, limit 7 → count 7;
  - load_i=en_i=1 with load_val 3 → count 3, not 4.
- Limit lowered: WRAP, up, count 9, limit_i changed to 4 → next count 0 with wrap_o pulse.
- Reset mid-run: in DONE with load_i=en_i=1, assert reset → next cycle count 0, done_o 0, wrap_o 0, FSM RUN.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types for the up/down modulo counter: end-of-range modes and FSM states.
package counter_pkg;

    typedef enum logic [1:0] {
        CNT_WRAP    = 2'b00,
        CNT_SAT     = 2'b01,
        CNT_ONESHOT = 2'b10,
        CNT_RSVD    = 2'b11
    } cnt_mode_t;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } cnt_state_t;

endpackage

// File: rtl/counter_updown_mod.sv
// Parametrised up/down counter over 0..limit_i with wrap, saturate and one-shot
// end-of-range behaviour, plus terminal, wrap-pulse and done status.
module counter_updown_mod
    import counter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             up_i,
    input  logic [WIDTH-1:0] limit_i,
    input  logic [1:0]       mode_i,
    output logic [WIDTH-1:0] count_o,
    output logic             tc_o,
    output logic             wrap_o,
    output logic             done_o
);

    logic [WIDTH-1:0] r_count;
    cnt_state_t       r_state;
    logic             r_wrap;

    logic [WIDTH-1:0] w_count_next;
    cnt_state_t       w_state_next;
    logic             w_wrap_next;
    logic             w_tc;
    cnt_mode_t        w_mode;

    assign w_mode = cnt_mode_t'(mode_i);

    always_comb begin
        w_count_next = r_count;
        w_state_next = r_state;
        w_wrap_next  = 1'b0;

        // >= rather than == so a limit lowered under the count still terminates
        w_tc = up_i ? (r_count >= limit_i) : (r_count == '0);

        if (load_i) begin
            w_count_next = (load_val_i > limit_i) ? limit_i : load_val_i;
            w_state_next = ST_RUN;
        end else if (en_i && (r_state == ST_RUN)) begin
            if (!w_tc) begin
                w_count_next = up_i ? (r_count + 1'b1) : (r_count - 1'b1);
            end else begin
                case (w_mode)
                    CNT_SAT:     w_count_next = r_count;
                    CNT_ONESHOT: w_state_next = ST_DONE;
                    default: begin
                        w_count_next = up_i ? '0 : limit_i;
                        w_wrap_next  = 1'b1;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_state <= ST_RUN;
            r_wrap  <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_state <= w_state_next;
            r_wrap  <= w_wrap_next;
        end
    end

    assign count_o = r_count;
    assign tc_o    = w_tc;
    assign wrap_o  = r_wrap;
    assign done_o  = (r_state == ST_DONE);

endmodule

// File: tb/tb_counter_updown_mod.sv
// Bench for counter_updown_mod (WIDTH=4): directed scenarios then random traffic,
// all checked against an integer reference model of the counting rules.
`timescale 1ns/1ps
module tb_counter_updown_mod;

    localparam int W = 4;

    logic         clk;
    logic         reset;
    logic         en_i;
    logic         load_i;
    logic [W-1:0] load_val_i;
    logic         up_i;
    logic [W-1:0] limit_i;
    logic [1:0]   mode_i;
    logic [W-1:0] count_o;
    logic         tc_o;
    logic         wrap_o;
    logic         done_o;

    int n_vec;
    int n_cmp;
    int n_err;

    int m_cnt;
    int m_done;
    int m_wrap;

    counter_updown_mod #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .en_i       (en_i),
        .load_i     (load_i),
        .load_val_i (load_val_i),
        .up_i       (up_i),
        .limit_i    (limit_i),
        .mode_i     (mode_i),
        .count_o    (count_o),
        .tc_o       (tc_o),
        .wrap_o     (wrap_o),
        .done_o     (done_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock of stimulus: check tc before the edge, advance the model, check registers after.
    task automatic step(input bit rst, input bit en, input bit ld, input int val,
                        input bit up, input int lim, input int mode);
        int tc_m;
        reset      = rst;
        en_i       = en;
        load_i     = ld;
        load_val_i = val[W-1:0];
        up_i       = up;
        limit_i    = lim[W-1:0];
        mode_i     = mode[1:0];
        #1;
        tc_m = up ? int'(m_cnt >= lim) : int'(m_cnt == 0);
        chk("tc", int'(tc_o), tc_m);
        if (rst) begin
            m_cnt = 0; m_done = 0; m_wrap = 0;
        end else if (ld) begin
            m_cnt = (val > lim) ? lim : val;
            m_done = 0; m_wrap = 0;
        end else if (en && m_done == 0) begin
            m_wrap = 0;
            if (tc_m == 0) m_cnt = up ? m_cnt + 1 : m_cnt - 1;
            else if (mode == 1) m_cnt = m_cnt;
            else if (mode == 2) m_done = 1;
            else begin
                m_cnt  = up ? 0 : lim;
                m_wrap = 1;
            end
        end else begin
            m_wrap = 0;
        end
        @(posedge clk);
        #1;
        n_vec++;
        chk("count", int'(count_o), m_cnt);
        chk("wrap", int'(wrap_o), m_wrap);
        chk("done", int'(done_o), m_done);
        $display("vec %0d rst=%0b en=%0b ld=%0b val=%0d up=%0b lim=%0d mode=%0d -> count=%0d tc=%0b wrap=%0b done=%0b",
                 n_vec, rst, en, ld, val, up, lim, mode, count_o, tc_o, wrap_o, done_o);
    endtask

    initial begin
        int r_lim, r_mode, r_val;
        bit r_up;
        n_vec = 0; n_cmp = 0; n_err = 0;
        m_cnt = 0; m_done = 0; m_wrap = 0;
        reset = 1'b1; en_i = 1'b0; load_i = 1'b0; load_val_i = '0;
        up_i = 1'b1; limit_i = 4'd9; mode_i = 2'b00;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_count", int'(count_o), 0);
        chk("rst_wrap", int'(wrap_o), 0);
        chk("rst_done", int'(done_o), 0);
        chk("rst_tc_up", int'(tc_o), 0);
        up_i = 1'b0;
        #1;
        chk("rst_tc_down", int'(tc_o), 1);
        up_i = 1'b1;

        // WRAP up to 9: 1..9,0,1,2
        for (int i = 0; i < 12; i++) step(0, 1, 0, 0, 1, 9, 0);
        chk("wrap_seq_end", int'(count_o), 2);

        // SAT down after loading 3: 2,1,0,0,0,0
        step(0, 0, 1, 3, 0, 9, 1);
        for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0, 9, 1);
        chk("sat_floor", int'(count_o), 0);

        // ONESHOT up to 5 then frozen, reload 2 and resume
        step(0, 0, 1, 0, 1, 5, 2);
        for (int i = 0; i < 10; i++) step(0, 1, 0, 0, 1, 5, 2);
        chk("oneshot_hold", int'(count_o), 5);
        chk("oneshot_done", int'(done_o), 1);
        step(0, 1, 0, 0, 1, 5, 0);
        step(0, 0, 1, 2, 1, 5, 2);
        step(0, 1, 0, 0, 1, 5, 2);
        step(0, 1, 0, 0, 1, 5, 2);
        chk("oneshot_resume", int'(count_o), 4);

        // Clamp and load-over-enable priority
        step(0, 0, 1, 12, 1, 7, 0);
        chk("clamp", int'(count_o), 7);
        step(0, 1, 1, 3, 1, 7, 0);
        chk("load_prio", int'(count_o), 3);

        // Limit lowered under the count
        step(0, 0, 1, 9, 1, 9, 0);
        step(0, 1, 0, 0, 1, 4, 0);
        chk("limit_low_cnt", int'(count_o), 0);
        chk("limit_low_wrap", int'(wrap_o), 1);

        // Down from above a lowered limit, then limit 0 in WRAP
        step(0, 0, 1, 9, 0, 9, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 4, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, i[0], 0, 0);
        chk("lim0_wrap", int'(wrap_o), 1);

        // Reset while in DONE with load and enable active
        step(0, 0, 1, 0, 1, 2, 2);
        for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 1, 2, 2);
        step(0, 1, 0, 0, 1, 2, 0);
        step(1, 1, 1, 6, 1, 9, 2);
        chk("midrst_count", int'(count_o), 0);
        chk("midrst_done", int'(done_o), 0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            r_lim  = (i % 50 < 5) ? 0 : int'($urandom_range(0, 15));
            r_mode = int'($urandom_range(0, 3));
            r_val  = int'($urandom_range(0, 15));
            r_up   = 1'($urandom_range(0, 1));
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 9) < 8),
                 ($urandom_range(0, 15) == 0), r_val, r_up, r_lim, r_mode);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
